// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 snake-direction controller.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_W       = 8'h1D;
  localparam logic [7:0] SC_S       = 8'h1B;
  localparam logic [7:0] SC_A       = 8'h1C;
  localparam logic [7:0] SC_D       = 8'h23;
  localparam logic [7:0] SC_SPACE   = 8'h29;
  localparam logic [7:0] SC_E_UP    = 8'h75;
  localparam logic [7:0] SC_E_DOWN  = 8'h72;
  localparam logic [7:0] SC_E_LEFT  = 8'h6B;
  localparam logic [7:0] SC_E_RIGHT = 8'h74;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

  // Returns {valid, direction} for a make code; valid=0 for non-direction keys.
  function automatic logic [2:0] decode_dir(input logic [7:0] sc, input logic ext);
    logic [2:0] r;
    r = 3'b000;
    if (!ext) begin
      case (sc)
        SC_W:    r = {1'b1, DIR_UP};
        SC_S:    r = {1'b1, DIR_DOWN};
        SC_A:    r = {1'b1, DIR_LEFT};
        SC_D:    r = {1'b1, DIR_RIGHT};
        default: r = 3'b000;
      endcase
    end else begin
      case (sc)
        SC_E_UP:    r = {1'b1, DIR_UP};
        SC_E_DOWN:  r = {1'b1, DIR_DOWN};
        SC_E_LEFT:  r = {1'b1, DIR_LEFT};
        SC_E_RIGHT: r = {1'b1, DIR_RIGHT};
        default:    r = 3'b000;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver in the system clock domain: sync, glitch filter, 11-bit
// frame FSM with odd-parity / stop check and a partial-frame timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [1:0]    clk_sync, dat_sync;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic          sample, sbit;

  frame_state_t  state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          timeout;

  assign sbit    = dat_sync[1];
  // Falling edge of the filtered clock, detected in the cycle it flips.
  assign sample  = filt && !clk_sync[1] && (fcnt == FW'(FILTER_LEN - 1));
  assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      fcnt     <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      if (clk_sync[1] != filt) begin
        if (fcnt == FW'(FILTER_LEN - 1)) begin
          filt <= clk_sync[1];
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (sample) begin
      case (state)
        IDLE:    if (!sbit) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      rx_byte    <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (sample || state == IDLE) tcnt <= '0;
      else                         tcnt <= tcnt + TW'(1);
      if (sample) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shreg   <= {sbit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par <= sbit;
          STOP: begin
            if ((^shreg ^ par) && sbit) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
            end else begin
              frame_err  <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (timeout) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_dir_ctrl.sv
// PS/2 keyboard to snake-game commands: make/break/extended decode plus a
// 2-deep direction queue drained one entry per game tick.
module ps2_dir_ctrl
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       game_tick,
  output logic [1:0] dir,
  output logic       dir_pending,
  output logic [7:0] scan_code,
  output logic       key_event,
  output logic       pause_toggle,
  output logic       frame_err
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       brk, ext;
  logic       cand_vld;
  logic [1:0] cand_dir;
  logic [2:0] dec;

  logic [1:0][1:0] q;
  logic [1:0]      qcnt, qcnt_nxt;
  logic [1:0]      ref_dir;
  logic            push, pop;

  ps2_rx_frame #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err)
  );

  assign dec = decode_dir(rx_byte, ext);

  always_ff @(posedge clk) begin
    if (rst) begin
      brk          <= 1'b0;
      ext          <= 1'b0;
      scan_code    <= '0;
      key_event    <= 1'b0;
      pause_toggle <= 1'b0;
      cand_vld     <= 1'b0;
      cand_dir     <= '0;
    end else begin
      key_event    <= 1'b0;
      pause_toggle <= 1'b0;
      cand_vld     <= 1'b0;
      if (byte_valid) begin
        if (rx_byte == SC_BREAK) begin
          brk <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext <= 1'b1;
        end else if (brk) begin
          brk <= 1'b0;
          ext <= 1'b0;
        end else begin
          scan_code    <= rx_byte;
          key_event    <= 1'b1;
          pause_toggle <= !ext && (rx_byte == SC_SPACE);
          cand_vld     <= dec[2];
          cand_dir     <= dec[1:0];
          ext          <= 1'b0;
        end
      end
    end
  end

  // Comparing only bit 1 (the axis) rejects both repeats and reversals.
  assign ref_dir  = (qcnt == 2'd0) ? dir : q[qcnt[1]];
  assign pop      = game_tick && (qcnt != 2'd0);
  assign push     = cand_vld && (cand_dir[1] != ref_dir[1]) && (qcnt != 2'd2 || pop);
  assign qcnt_nxt = qcnt + 2'(push) - 2'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      dir         <= DIR_RIGHT;
      dir_pending <= 1'b0;
      qcnt        <= '0;
      q           <= '0;
    end else begin
      qcnt        <= qcnt_nxt;
      dir_pending <= (qcnt_nxt != 2'd0);
      if (pop) dir <= q[0];
      case ({push, pop})
        2'b10: q[qcnt[0]] <= cand_dir;
        2'b01: q[0] <= q[1];
        2'b11: begin
          if (qcnt == 2'd1) begin
            q[0] <= cand_dir;
          end else begin
            q[0] <= q[1];
            q[1] <= cand_dir;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_dir_ctrl.sv
// Self-checking bench: PS/2 frames driven at 400-clk bit period, results
// compared against a queue-based model of the decoder and direction FIFO.
module tb_ps2_dir_ctrl;

  localparam int FL   = 4;
  localparam int TO   = 2000;
  localparam int HALF = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       game_tick = 1'b0;
  logic [1:0] dir;
  logic       dir_pending;
  logic [7:0] scan_code;
  logic       key_event, pause_toggle, frame_err;

  int checks = 0;
  int failures = 0;
  int n_key = 0, n_pause = 0, n_err = 0;

  logic [1:0] m_dir;
  logic [1:0] m_q[$];
  bit         m_brk, m_ext;
  int         m_key, m_pause, m_err;
  logic [7:0] m_scan;

  ps2_dir_ctrl #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .game_tick    (game_tick),
    .dir          (dir),
    .dir_pending  (dir_pending),
    .scan_code    (scan_code),
    .key_event    (key_event),
    .pause_toggle (pause_toggle),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (key_event)    n_key++;
      if (pause_toggle) n_pause++;
      if (frame_err)    n_err++;
    end
  end

  initial begin
    #990000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic bit vertical(input logic [1:0] d);
    return (d == 2'b00) || (d == 2'b01);
  endfunction

  function automatic void model_reset();
    m_dir = 2'b11; m_q = {}; m_brk = 0; m_ext = 0; m_scan = 8'h00;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit has;
    logic [1:0] d, r;
    has = 1; d = 2'b00;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_brk) begin m_brk = 0; m_ext = 0; end
    else begin
      m_scan = b; m_key++;
      if (!m_ext) begin
        case (b)
          8'h1D: d = 2'b00;
          8'h1B: d = 2'b01;
          8'h1C: d = 2'b10;
          8'h23: d = 2'b11;
          8'h29: begin has = 0; m_pause++; end
          default: has = 0;
        endcase
      end else begin
        case (b)
          8'h75: d = 2'b00;
          8'h72: d = 2'b01;
          8'h6B: d = 2'b10;
          8'h74: d = 2'b11;
          default: has = 0;
        endcase
      end
      m_ext = 0;
      if (has) begin
        r = (m_q.size() != 0) ? m_q[$] : m_dir;
        if (vertical(d) != vertical(r) && m_q.size() < 2) m_q.push_back(d);
      end
    end
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] fr;
    logic p;
    p = bad_par ? ^b : ~^b;
    fr = {1'b1, p, b, 1'b0};
    send_bits(fr, 11);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk) game_tick = 1'b1;
    @(negedge clk) game_tick = 1'b0;
    if (m_q.size() != 0) m_dir = m_q.pop_front();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    model_reset(); m_key = 0; m_pause = 0; m_err = 0;
    @(negedge clk);
    checks++; if (dir !== 2'b11) begin failures++; $display("FAIL reset_dir got=%b exp=11", dir); end
    checks++; if (dir_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", dir_pending); end
    checks++; if (scan_code !== 8'h00) begin failures++; $display("FAIL reset_scan got=%h exp=00", scan_code); end
    checks++; if ({key_event, pause_toggle, frame_err} !== 3'b000) begin
      failures++; $display("FAIL reset_pulses got=%b exp=000", {key_event, pause_toggle, frame_err});
    end
  endtask

  task automatic test_reversal();
    send_frame(8'h1C, 0); model_byte(8'h1C);
    send_frame(8'h23, 0); model_byte(8'h23);
    checks++; if (dir_pending !== 1'b0) begin failures++; $display("FAIL rev_pending got=%b exp=0", dir_pending); end
    checks++; if (n_key !== m_key) begin failures++; $display("FAIL rev_keys got=%0d exp=%0d", n_key, m_key); end
    do_tick();
    checks++; if (dir !== 2'b11) begin failures++; $display("FAIL rev_dir got=%b exp=11", dir); end
  endtask

  task automatic test_sequence();
    logic [7:0] seq [5];
    seq = '{8'hE0, 8'h75, 8'hE0, 8'h6B, 8'h1B};
    for (int i = 0; i < 5; i++) begin send_frame(seq[i], 0); model_byte(seq[i]); end
    checks++; if (dir_pending !== 1'b1) begin failures++; $display("FAIL seq_pending got=%b exp=1", dir_pending); end
    checks++; if (scan_code !== 8'h1B) begin failures++; $display("FAIL seq_scan got=%h exp=1b", scan_code); end
    do_tick();
    checks++; if (dir !== 2'b00 || dir !== m_dir) begin failures++; $display("FAIL seq_tick1 got=%b exp=00", dir); end
    do_tick();
    checks++; if (dir !== 2'b10 || dir !== m_dir) begin failures++; $display("FAIL seq_tick2 got=%b exp=10", dir); end
    checks++; if (dir_pending !== 1'b0) begin failures++; $display("FAIL seq_drained got=%b exp=0", dir_pending); end
  endtask

  task automatic test_basic();
    send_frame(8'h1D, 0); model_byte(8'h1D);
    checks++; if (n_key !== m_key) begin failures++; $display("FAIL basic_keys got=%0d exp=%0d", n_key, m_key); end
    checks++; if (scan_code !== 8'h1D) begin failures++; $display("FAIL basic_scan got=%h exp=1d", scan_code); end
    checks++; if (dir_pending !== 1'b1) begin failures++; $display("FAIL basic_pending got=%b exp=1", dir_pending); end
    do_tick();
    checks++; if (dir !== 2'b00) begin failures++; $display("FAIL basic_dir got=%b exp=00", dir); end
    checks++; if (dir_pending !== 1'b0) begin failures++; $display("FAIL basic_pending2 got=%b exp=0", dir_pending); end
  endtask

  task automatic test_break_pause();
    send_frame(8'hF0, 0); model_byte(8'hF0);
    send_frame(8'h1D, 0); model_byte(8'h1D);
    checks++; if (n_key !== m_key) begin failures++; $display("FAIL brk_keys got=%0d exp=%0d", n_key, m_key); end
    checks++; if (dir_pending !== 1'b0) begin failures++; $display("FAIL brk_pending got=%b exp=0", dir_pending); end
    send_frame(8'h29, 0); model_byte(8'h29);
    checks++; if (n_pause !== m_pause) begin failures++; $display("FAIL pause_cnt got=%0d exp=%0d", n_pause, m_pause); end
    checks++; if (scan_code !== 8'h29) begin failures++; $display("FAIL pause_scan got=%h exp=29", scan_code); end
  endtask

  task automatic test_parity();
    send_frame(8'h1D, 1); m_err++;
    checks++; if (n_err !== m_err) begin failures++; $display("FAIL par_err got=%0d exp=%0d", n_err, m_err); end
    checks++; if (n_key !== m_key) begin failures++; $display("FAIL par_keys got=%0d exp=%0d", n_key, m_key); end
  endtask

  task automatic test_timeout();
    logic [10:0] fr;
    fr = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
    send_bits(fr, 4);
    ps2_data = 1'b1;
    repeat (TO + 300) @(negedge clk);
    m_err++;
    checks++; if (n_err !== m_err) begin failures++; $display("FAIL timeout_err got=%0d exp=%0d", n_err, m_err); end
    send_frame(8'h23, 0); model_byte(8'h23);
    checks++; if (scan_code !== 8'h23) begin failures++; $display("FAIL timeout_scan got=%h exp=23", scan_code); end
    checks++; if (n_key !== m_key) begin failures++; $display("FAIL timeout_keys got=%0d exp=%0d", n_key, m_key); end
    checks++; if (dir_pending !== (m_q.size() != 0)) begin failures++; $display("FAIL timeout_pending got=%b exp=%b", dir_pending, m_q.size() != 0); end
  endtask

  task automatic test_glitch();
    ps2_data = 1'b0;
    @(negedge clk) ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk);
    send_frame(8'h1B, 0); model_byte(8'h1B);
    checks++; if (n_err !== m_err) begin failures++; $display("FAIL glitch_err got=%0d exp=%0d", n_err, m_err); end
    checks++; if (scan_code !== 8'h1B) begin failures++; $display("FAIL glitch_scan got=%h exp=1b", scan_code); end
    checks++; if (dir_pending !== (m_q.size() != 0)) begin failures++; $display("FAIL glitch_pending got=%b exp=%b", dir_pending, m_q.size() != 0); end
  endtask

  task automatic test_random();
    logic [7:0] pool [12];
    logic [7:0] b;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'hE0, 8'hF0, 8'h00};
    for (int i = 0; i < 2; i++) begin
      if ($urandom_range(0, 1) == 1) do_tick();
      b = pool[$urandom_range(0, 11)];
      if (b == 8'h00) b = 8'($urandom_range(1, 255));
      send_frame(b, 0); model_byte(b);
      checks++; if (n_key !== m_key) begin failures++; $display("FAIL rnd_keys b=%h got=%0d exp=%0d", b, n_key, m_key); end
      checks++; if (scan_code !== m_scan) begin failures++; $display("FAIL rnd_scan b=%h got=%h exp=%h", b, scan_code, m_scan); end
      checks++; if (n_pause !== m_pause) begin failures++; $display("FAIL rnd_pause got=%0d exp=%0d", n_pause, m_pause); end
      do_tick();
      checks++; if (dir !== m_dir) begin failures++; $display("FAIL rnd_dir got=%b exp=%b", dir, m_dir); end
      checks++; if (dir_pending !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_pending got=%b exp=%b", dir_pending, m_q.size() != 0); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] fr;
    fr = {1'b1, ~^8'hA5, 8'hA5, 1'b0};
    send_bits(fr, 5);
    ps2_data = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if (dir !== 2'b11) begin failures++; $display("FAIL rstmid_dir got=%b exp=11", dir); end
    checks++; if (dir_pending !== 1'b0) begin failures++; $display("FAIL rstmid_pending got=%b exp=0", dir_pending); end
    checks++; if (scan_code !== 8'h00) begin failures++; $display("FAIL rstmid_scan got=%h exp=00", scan_code); end
    send_frame(8'h1D, 0); model_byte(8'h1D);
    checks++; if (scan_code !== 8'h1D) begin failures++; $display("FAIL rstmid_after got=%h exp=1d", scan_code); end
    checks++; if (n_err !== m_err) begin failures++; $display("FAIL rstmid_err got=%0d exp=%0d", n_err, m_err); end
  endtask

  initial begin
    test_reset();
    test_reversal();
    test_sequence();
    test_basic();
    test_break_pause();
    test_parity();
    test_timeout();
    test_glitch();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
